fetch_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode and the hazard unit.
- Owns PCF and performs a single-outstanding valid/ready fetch from instruction memory with variable latency.
- Honours StallF/StallD/FlushD from the hazard unit and branch redirects from execute.
- Delivers InstrD/PCD/PCPlus4D to decode, inserting NOP bubbles when memory is slow.

---
 rtl/fetch_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with single-outstanding imem handshake and IF/ID register
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req_valid,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD,
  output logic                  FetchBusy
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pcf_q, pcf_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pcd_q, pcd_d;
  logic [DATA_WIDTH-1:0] pcp4_q, pcp4_d;
  logic                  valid_q, valid_d;

  logic                  advance;
  logic                  avail;
  logic                  deliver;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] fetched_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pcf_q   <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    advance       = !StallF && !StallD;
    pc_plus4      = pcf_q + DATA_WIDTH'(4);
    avail         = (state_q == S_HOLD) || (state_q == S_WAIT && imem_resp_valid && !kill_q);
    deliver       = avail && advance && !PCSrcE;
    fetched_instr = (state_q == S_HOLD) ? hold_q : imem_resp_data;

    state_d = state_q;
    kill_d  = kill_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = PCSrcE;
        end
      end
      S_WAIT: begin
        // A redirect kills the in-flight fetch: drop it now if it is here, otherwise mark it
        if (PCSrcE) begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (kill_q) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else if (advance) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            hold_d  = imem_resp_data;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE || advance) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (PCSrcE)       pcf_d = PCTargetE & ALIGN_MASK;
    else if (deliver) pcf_d = pc_plus4;
    else              pcf_d = pcf_q;

    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD || (!StallD && !deliver)) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      instr_d = fetched_instr;
      pcd_d   = pcf_q;
      pcp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    imem_req_valid = rst_n && (state_q == S_REQ);
    imem_req_addr  = pcf_q & ALIGN_MASK;
    FetchBusy      = !avail;
    InstrD         = instr_q;
    PCD            = pcd_q;
    PCPlus4D       = pcp4_q;
    ValidD         = valid_q;
  end

endmodule
